// File: rtl/load_store_unit.sv
// load_store_unit: turns CPU byte/halfword/word loads and stores into
// whole-word accesses on a big-endian, combinational-read data memory.
// Sub-word stores go through a read-modify-write of the containing word.
// Misaligned, reserved-size and out-of-range requests complete with error
// set and never touch memory.
// Optional build macro LSU_STATS_EN adds loadCount/storeCount outputs
// that count successful loads and stores (16-bit, wrapping).
module load_store_unit #(
  parameter int MEM_BYTES  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  isStore,
  input  logic [1:0]            size,
  input  logic                  signExtend,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           storeData,
  output logic [31:0]           loadData,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memWriteData,
  output logic                  memWriteEnable,
  input  logic [31:0]           memReadData
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]           loadCount,
  output logic [15:0]           storeCount
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // One extra bit so aligned+3 cannot wrap near the top of the address space.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH:0] LAST_OFS  = (ADDR_WIDTH + 1)'(3);

  state_t                  state_reg;
  logic                    is_store_reg;
  logic [1:0]              size_reg;
  logic                    sign_ext_reg;
  logic [1:0]              offset_reg;
  logic [15:0]             store_data_reg;
  logic [31:0]             load_data_reg;
  logic                    done_reg;
  logic                    error_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [31:0]             wdata_reg;
  logic                    we_reg;

  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic                    range_bad;
  logic                    req_error;
  logic [7:0]              rd_lane    [4];
  logic [7:0]              merge_lane [4];
  logic [31:0]             merge_word;
  logic [15:0]             half_word;
  logic [31:0]             load_value;

  assign aligned_addr = {address[ADDR_WIDTH-1:2], 2'b00};
  assign range_bad    = ({1'b0, aligned_addr} + LAST_OFS) >= MEM_LIMIT;

  // Reject illegal requests at acceptance so they never reach memory.
  always_comb begin
    req_error = 1'b0;
    case (size)
      SIZE_HALF: if (address[0]) req_error = 1'b1;
      SIZE_WORD: if (address[1:0] != 2'b00) req_error = 1'b1;
      SIZE_RSVD: req_error = 1'b1;
      default:   req_error = 1'b0;
    endcase
    if (range_bad) req_error = 1'b1;
  end

  // Big-endian lanes: lane 0 is bits [31:24], lane 3 is bits [7:0].
  // A lane takes store data when the access covers it; halfword stores put
  // storeData[15:8] in the even lane and storeData[7:0] in the odd one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] store_lane;

      assign rd_lane[gi] = memReadData[31-8*gi -: 8];

      assign lane_hit = (size_reg == SIZE_BYTE) ? (offset_reg == 2'(gi)) :
                        (size_reg == SIZE_HALF) ? (offset_reg[1] == (gi >= 2)) :
                        1'b1;

      assign store_lane = ((size_reg == SIZE_HALF) && (gi % 2 == 0)) ?
                          store_data_reg[15:8] : store_data_reg[7:0];

      assign merge_lane[gi] = lane_hit ? store_lane : rd_lane[gi];
    end
  endgenerate

  assign merge_word = {merge_lane[0], merge_lane[1], merge_lane[2], merge_lane[3]};

  // Lane select and sign/zero extension of the word being read.
  always_comb begin
    half_word  = offset_reg[1] ? memReadData[15:0] : memReadData[31:16];
    load_value = memReadData;
    case (size_reg)
      SIZE_BYTE: load_value = {{24{sign_ext_reg & rd_lane[offset_reg][7]}},
                               rd_lane[offset_reg]};
      SIZE_HALF: load_value = {{16{sign_ext_reg & half_word[15]}}, half_word};
      default:   load_value = memReadData;
    endcase
  end

`ifdef LSU_STATS_EN
  logic [15:0] load_count_reg;
  logic [15:0] store_count_reg;
`endif

  // Request FSM with registered outputs; done/we are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      is_store_reg   <= 1'b0;
      size_reg       <= 2'b00;
      sign_ext_reg   <= 1'b0;
      offset_reg     <= 2'b00;
      store_data_reg <= '0;
      load_data_reg  <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      mem_addr_reg   <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
`ifdef LSU_STATS_EN
      load_count_reg  <= '0;
      store_count_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      we_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            is_store_reg   <= isStore;
            size_reg       <= size;
            sign_ext_reg   <= signExtend;
            offset_reg     <= address[1:0];
            store_data_reg <= storeData[15:0];
            load_data_reg  <= '0;
            error_reg      <= req_error;
            if (req_error) begin
              done_reg  <= 1'b1;
              state_reg <= RESP;
            end else begin
              mem_addr_reg <= aligned_addr;
              if (isStore && (size == SIZE_WORD)) begin
                // Full word needs no read: write storeData directly.
                wdata_reg <= storeData;
                we_reg    <= 1'b1;
                state_reg <= WRITE;
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        READ: begin
          if (is_store_reg) begin
            wdata_reg <= merge_word;
            we_reg    <= 1'b1;
            state_reg <= WRITE;
          end else begin
            load_data_reg <= load_value;
            done_reg      <= 1'b1;
            state_reg     <= RESP;
`ifdef LSU_STATS_EN
            load_count_reg <= load_count_reg + 16'd1;
`endif
          end
        end
        WRITE: begin
          done_reg  <= 1'b1;
          state_reg <= RESP;
`ifdef LSU_STATS_EN
          store_count_reg <= store_count_reg + 16'd1;
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign loadData       = load_data_reg;
  assign done           = done_reg;
  assign busy           = (state_reg != IDLE);
  assign error          = error_reg;
  assign memAddress     = mem_addr_reg;
  assign memWriteData   = wdata_reg;
  // Reset arriving during WRITE must keep the memory word untouched.
  assign memWriteEnable = we_reg & ~reset;

`ifdef LSU_STATS_EN
  assign loadCount  = load_count_reg;
  assign storeCount = store_count_reg;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 1 KiB word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        isStore;
  logic [1:0]  size;
  logic        signExtend;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        done;
  logic        busy;
  logic        error;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic [31:0] memReadData;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  int          we_count;
  logic [31:0] we_addr;

  load_store_unit #(.MEM_BYTES(1024), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .isStore(isStore), .size(size),
    .signExtend(signExtend), .address(address), .storeData(storeData),
    .loadData(loadData), .done(done), .busy(busy), .error(error),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memReadData = mem[memAddress[9:2]];

  // Memory model: bench preload port plus the DUT write port.
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (memWriteEnable) begin
      mem[memAddress[9:2]] <= memWriteData;
      we_count <= we_count + 1;
      we_addr  <= memAddress;
    end
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one request and wait (bounded) for done; lat counts cycles from start.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic se,
                           input logic [31:0] addr, input logic [31:0] sd,
                           output int lat, output logic [31:0] ld, output logic err);
    @(negedge clk);
    start = 1'b1; isStore = st; size = sz; signExtend = se;
    address = addr; storeData = sd;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = 99;
    ld  = loadData;
    err = error;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (loadData !== 32'h0) begin errors++; $display("FAIL reset_loadData got %h want %h", loadData, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (memAddress !== 32'h0) begin errors++; $display("FAIL reset_memAddress got %h want 0", memAddress); end
    checks++; if (memWriteData !== 32'h0) begin errors++; $display("FAIL reset_memWriteData got %h want 0", memWriteData); end
    checks++; if (memWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_memWriteEnable got %b want 0", memWriteEnable); end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_loads();
    int lat; logic [31:0] ld; logic err;
    poke(8'd4, 32'h80FF1234);
    do_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, ld, err);
    $display("load byte 0x10 sext: data %h lat %0d err %b", ld, lat, err);
    checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext_data got %h want %h", ld, 32'hFFFFFF80); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lb_latency got %0d want 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lb_error got %b want 0", err); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse got done %b busy %b want 0 0", done, busy); end
    do_access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, ld, err);
    $display("load byte 0x10 zext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'h00000080) begin errors++; $display("FAIL lb_zext_data got %h want %h", ld, 32'h00000080); end
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, ld, err);
    $display("load byte 0x13 sext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'h00000034) begin errors++; $display("FAIL lb_lane3 got %h want %h", ld, 32'h00000034); end
    do_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, ld, err);
    $display("load byte 0x11 sext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_lane1 got %h want %h", ld, 32'hFFFFFFFF); end
    do_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, ld, err);
    $display("load half 0x12 sext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'h00001234) begin errors++; $display("FAIL lh_low got %h want %h", ld, 32'h00001234); end
    do_access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, ld, err);
    $display("load half 0x10 zext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'h000080FF) begin errors++; $display("FAIL lh_zext got %h want %h", ld, 32'h000080FF); end
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] ld; logic err; int we0;
    poke(8'd4, 32'h11223344);
    we0 = we_count;
    do_access(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, lat, ld, err);
    $display("store byte 0x12: mem %h lat %0d writes %0d", mem[4], lat, we_count - we0);
    checks++; if (mem[4] !== 32'h1122AB44) begin errors++; $display("FAIL sb_merge got %h want %h", mem[4], 32'h1122AB44); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
    checks++; if (we_count - we0 != 1) begin errors++; $display("FAIL sb_write_count got %0d want 1", we_count - we0); end
    checks++; if (we_addr !== 32'h10) begin errors++; $display("FAIL sb_write_addr got %h want %h", we_addr, 32'h10); end
  endtask

  task automatic test_halfword();
    int lat; logic [31:0] ld; logic err;
    poke(8'd4, 32'h11223344);
    do_access(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, lat, ld, err);
    $display("store half 0x10: mem %h lat %0d", mem[4], lat);
    checks++; if (mem[4] !== 32'hBEEF3344) begin errors++; $display("FAIL sh_hi got %h want %h", mem[4], 32'hBEEF3344); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
    do_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, ld, err);
    $display("load half 0x10 sext: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_sext got %h want %h", ld, 32'hFFFFBEEF); end
    do_access(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF5678, lat, ld, err);
    $display("store half 0x12: mem %h lat %0d", mem[4], lat);
    checks++; if (mem[4] !== 32'hBEEF5678) begin errors++; $display("FAIL sh_lo got %h want %h", mem[4], 32'hBEEF5678); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] ld; logic err; int we0;
    we0 = we_count;
    do_access(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, lat, ld, err);
    $display("store word 0x14: mem %h lat %0d writes %0d", mem[5], lat, we_count - we0);
    checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got %h want %h", mem[5], 32'hDEADBEEF); end
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (we_count - we0 != 1) begin errors++; $display("FAIL sw_write_count got %0d want 1", we_count - we0); end
    do_access(1'b0, 2'b10, 1'b1, 32'h14, 32'h0, lat, ld, err);
    $display("load word 0x14: data %h lat %0d", ld, lat);
    checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want %h", ld, 32'hDEADBEEF); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
    do_access(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, lat, ld, err);
    do_access(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, ld, err);
    $display("word 0x3FC round trip: data %h err %b", ld, err);
    checks++; if (ld !== 32'hCAFEF00D || err !== 1'b0) begin errors++; $display("FAIL top_word got %h err %b want %h err 0", ld, err, 32'hCAFEF00D); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] ld; logic err; int we0;
    logic        st_t   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz_t   [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01};
    logic [31:0] addr_t [6] = '{32'h12, 32'h11, 32'h10, 32'h3FE, 32'h400, 32'h11};
    for (int i = 0; i < 6; i++) begin
      we0 = we_count;
      do_access(st_t[i], sz_t[i], 1'b0, addr_t[i], 32'h12345678, lat, ld, err);
      $display("error case %0d: st %b size %b addr %h err %b lat %0d data %h", i, st_t[i], sz_t[i], addr_t[i], err, lat, ld);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag case %0d got %b want 1", i, err); end
      checks++; if (lat != 1) begin errors++; $display("FAIL err_latency case %0d got %0d want 1", i, lat); end
      checks++; if (we_count != we0) begin errors++; $display("FAIL err_no_write case %0d got %0d writes want 0", i, we_count - we0); end
      checks++; if (ld !== 32'h0) begin errors++; $display("FAIL err_loadData case %0d got %h want 0", i, ld); end
    end
  endtask

  task automatic test_reset_during_write();
    int we0;
    poke(8'd4, 32'h11223344);
    we0 = we_count;
    @(negedge clk);
    start = 1'b1; isStore = 1'b1; size = 2'b00; signExtend = 1'b0;
    address = 32'h12; storeData = 32'h000000AB;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (memWriteEnable !== 1'b1) begin errors++; $display("FAIL rst_write_cycle got we %b want 1", memWriteEnable); end
    reset = 1'b1;
    @(negedge clk);
    $display("reset in WRITE: mem %h writes %0d busy %b", mem[4], we_count - we0, busy);
    checks++; if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL rst_mem got %h want %h", mem[4], 32'h11223344); end
    checks++; if (we_count != we0) begin errors++; $display("FAIL rst_no_write got %0d writes want 0", we_count - we0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_flags got busy %b done %b error %b want 0 0 0", busy, done, error); end
    checks++; if (memAddress !== 32'h0 || memWriteData !== 32'h0 || memWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_mem_port got %h %h %b want 0 0 0", memAddress, memWriteData, memWriteEnable); end
    reset = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int we0; int done_cnt; int done_at; logic busy1;
    poke(8'd4, 32'h11223344);
    poke(8'd8, 32'h00000000);
    we0 = we_count; done_cnt = 0; done_at = -1; busy1 = 1'b0;
    @(negedge clk);
    start = 1'b1; isStore = 1'b1; size = 2'b00; signExtend = 1'b0;
    address = 32'h13; storeData = 32'h000000AB;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      // Conflicting word store held on start while the unit is busy.
      isStore = 1'b1; size = 2'b10; address = 32'h20; storeData = 32'h55555555;
      if (c == 4) start = 1'b0;
      if (c == 1) busy1 = busy;
      if (done) begin done_cnt++; done_at = c; end
    end
    $display("busy ignore: dones %0d at %0d mem4 %h mem8 %h", done_cnt, done_at, mem[4], mem[8]);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_high got %b want 1", busy1); end
    checks++; if (done_cnt != 1 || done_at != 3) begin errors++; $display("FAIL busy_done got %0d at %0d want 1 at 3", done_cnt, done_at); end
    checks++; if (mem[4] !== 32'h112233AB) begin errors++; $display("FAIL busy_merge got %h want %h", mem[4], 32'h112233AB); end
    checks++; if (mem[8] !== 32'h0 || we_count - we0 != 1) begin errors++; $display("FAIL busy_ignored got mem8 %h writes %0d want 0 1", mem[8], we_count - we0); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; isStore = 1'b0; size = 2'b00; signExtend = 1'b0;
    address = '0; storeData = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    we_count = 0; we_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_byte_store();
    test_halfword();
    test_word();
    test_errors();
    test_reset_during_write();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
